// File: rtl/x86_inst_encoder_if.sv
// Byte-stream bus for x86_inst_encoder: descriptor input handshake,
// serialized byte output handshake and the accepted-instruction length.
interface x86_inst_encoder_if #(
  parameter int DISP_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic              in_legacy_en;
  logic [7:0]        in_legacy;
  logic              in_rex_en;
  logic [3:0]        in_rex_wrxb;
  logic              in_two_byte;
  logic [7:0]        in_opcode;
  logic              in_modrm_en;
  logic [7:0]        in_modrm;
  logic [7:0]        in_sib;
  logic [DISP_W-1:0] in_disp;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              out_last;
  logic [3:0]        inst_len;

  // Descriptor source / byte sink side
  modport master (
    output in_valid, in_legacy_en, in_legacy, in_rex_en, in_rex_wrxb,
           in_two_byte, in_opcode, in_modrm_en, in_modrm, in_sib, in_disp,
           out_ready,
    input  in_ready, out_valid, out_byte, out_last, inst_len
  );

  // Encoder side
  modport slave (
    input  in_valid, in_legacy_en, in_legacy, in_rex_en, in_rex_wrxb,
           in_two_byte, in_opcode, in_modrm_en, in_modrm, in_sib, in_disp,
           out_ready,
    output in_ready, out_valid, out_byte, out_last, inst_len
  );
endinterface

// File: rtl/x86_inst_encoder.sv
// x86_inst_encoder: serializes one x86-64 instruction descriptor into its
// byte stream (legacy, REX, 0F, opcode, ModRM, SIB, disp), one byte per
// handshake. Optional ASCII hex trace port enabled by ENC_ASCII_TRACE_EN.
module x86_inst_encoder #(
  parameter int DISP_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  x86_inst_encoder_if.slave   bus
`ifdef ENC_ASCII_TRACE_EN
  ,
  output logic [191:0]        trace_stream
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEGACY = 3'd1;
  localparam logic [2:0] S_REX    = 3'd2;
  localparam logic [2:0] S_ESC    = 3'd3;
  localparam logic [2:0] S_OPC    = 3'd4;
  localparam logic [2:0] S_MODRM  = 3'd5;
  localparam logic [2:0] S_SIB    = 3'd6;
  localparam logic [2:0] S_DISP   = 3'd7;

  // SIB follows ModRM for memory forms with rm=100
  function automatic logic sib_needed(input logic en, input logic [7:0] m);
    return en && (m[7:6] != 2'b11) && (m[2:0] == 3'b100);
  endfunction

  // Displacement byte count implied by mod/rm (and SIB base for mod=00)
  function automatic logic [2:0] disp_len(input logic en, input logic [7:0] m,
                                          input logic [7:0] s);
    logic sp;
    sp = sib_needed(en, m);
    if (!en) return 3'd0;
    case (m[7:6])
      2'b01:   return 3'd1;
      2'b10:   return 3'd4;
      2'b00:   return ((m[2:0] == 3'b101) || (sp && s[2:0] == 3'b101)) ? 3'd4 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0]  state_q, state_d, after_s, first_s;
  logic [1:0]  disp_cnt_q;
  logic [3:0]  inst_len_q;
  logic        accept, hs;
  logic [7:0]  byte_o;
  logic        last_o;
  logic [31:0] disp_ext;

  // Latched descriptor fields (no reset needed: only read outside IDLE)
  logic        legacy_en_q, rex_en_q, two_byte_q, modrm_en_q, sib_pres_q;
  logic [7:0]  legacy_q, opcode_q, modrm_q, sib_q;
  logic [3:0]  wrxb_q;
  logic [31:0] disp_q;
  logic [2:0]  disp_bytes_q;
  logic        in_sib_pres;
  logic [2:0]  in_disp_bytes;

  if (DISP_W >= 32) begin : g_disp_wide
    assign disp_ext = bus.in_disp[31:0];
  end else begin : g_disp_narrow
    assign disp_ext = {{(32-DISP_W){1'b0}}, bus.in_disp};
  end

  assign in_sib_pres   = sib_needed(bus.in_modrm_en, bus.in_modrm);
  assign in_disp_bytes = disp_len(bus.in_modrm_en, bus.in_modrm, bus.in_sib);

  assign bus.in_ready  = (state_q == S_IDLE) && !reset;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q != S_IDLE);
  assign hs            = bus.out_valid && bus.out_ready;
  assign bus.out_byte  = byte_o;
  assign bus.out_last  = last_o;
  assign bus.inst_len  = inst_len_q;

  // First byte state chosen from the incoming descriptor
  always_comb begin
    first_s = S_OPC;
    if (bus.in_legacy_en)     first_s = S_LEGACY;
    else if (bus.in_rex_en)   first_s = S_REX;
    else if (bus.in_two_byte) first_s = S_ESC;
  end

  // State following the current byte, from the latched descriptor
  always_comb begin
    after_s = S_IDLE;
    case (state_q)
      S_LEGACY: after_s = rex_en_q ? S_REX : (two_byte_q ? S_ESC : S_OPC);
      S_REX:    after_s = two_byte_q ? S_ESC : S_OPC;
      S_ESC:    after_s = S_OPC;
      S_OPC:    after_s = modrm_en_q ? S_MODRM : S_IDLE;
      S_MODRM:  after_s = sib_pres_q ? S_SIB :
                          ((disp_bytes_q != 3'd0) ? S_DISP : S_IDLE);
      S_SIB:    after_s = (disp_bytes_q != 3'd0) ? S_DISP : S_IDLE;
      S_DISP:   after_s = ((3'({1'b0, disp_cnt_q}) + 3'd1) == disp_bytes_q) ? S_IDLE : S_DISP;
      default:  after_s = S_IDLE;
    endcase
  end

  // Next state: accept from IDLE, advance on byte handshake
  always_comb begin
    state_d = state_q;
    if (accept)  state_d = first_s;
    else if (hs) state_d = after_s;
  end

  // Current output byte and last flag, held while the state holds
  always_comb begin
    byte_o = 8'h00;
    case (state_q)
      S_LEGACY: byte_o = legacy_q;
      S_REX:    byte_o = {4'b0100, wrxb_q};
      S_ESC:    byte_o = 8'h0F;
      S_OPC:    byte_o = opcode_q;
      S_MODRM:  byte_o = modrm_q;
      S_SIB:    byte_o = sib_q;
      S_DISP: begin
        case (disp_cnt_q)
          2'd0:    byte_o = disp_q[7:0];
          2'd1:    byte_o = disp_q[15:8];
          2'd2:    byte_o = disp_q[23:16];
          default: byte_o = disp_q[31:24];
        endcase
      end
      default:  byte_o = 8'h00;
    endcase
    last_o = (state_q != S_IDLE) && (after_s == S_IDLE);
  end

  // Control state, length and displacement counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      inst_len_q <= 4'd0;
      disp_cnt_q <= 2'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        inst_len_q <= 4'd1 + 4'(bus.in_legacy_en) + 4'(bus.in_rex_en) +
                      4'(bus.in_two_byte) + 4'(bus.in_modrm_en) +
                      4'(in_sib_pres) + 4'(in_disp_bytes);
        disp_cnt_q <= 2'd0;
      end else if (hs && state_q == S_DISP) begin
        disp_cnt_q <= disp_cnt_q + 2'd1;
      end
    end
  end

  // Descriptor capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      legacy_en_q  <= bus.in_legacy_en;
      legacy_q     <= bus.in_legacy;
      rex_en_q     <= bus.in_rex_en;
      wrxb_q       <= bus.in_rex_wrxb;
      two_byte_q   <= bus.in_two_byte;
      opcode_q     <= bus.in_opcode;
      modrm_en_q   <= bus.in_modrm_en;
      modrm_q      <= bus.in_modrm;
      sib_q        <= bus.in_sib;
      disp_q       <= disp_ext;
      sib_pres_q   <= in_sib_pres;
      disp_bytes_q <= in_disp_bytes;
    end
  end

`ifdef ENC_ASCII_TRACE_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h57 + 8'(n));
  endfunction

  logic [191:0] trace_q, trace_d;
  logic [3:0]   tr_cnt_q, tr_cnt_d;

  assign trace_stream = trace_q;

  // Append "xx " for each of the first eight handshaken bytes
  always_comb begin
    trace_d  = trace_q;
    tr_cnt_d = tr_cnt_q;
    if (accept) begin
      trace_d  = {24{8'h20}};
      tr_cnt_d = 4'd0;
    end else if (hs && tr_cnt_q < 4'd8) begin
      trace_d[191 - 24*int'(tr_cnt_q) -: 24] = {hex_char(byte_o[7:4]), hex_char(byte_o[3:0]), 8'h20};
      tr_cnt_d = tr_cnt_q + 4'd1;
    end
  end

  // Trace register, cleared to spaces on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_q  <= {24{8'h20}};
      tr_cnt_q <= 4'd0;
    end else begin
      trace_q  <= trace_d;
      tr_cnt_q <= tr_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_x86_inst_encoder.sv
// Testbench for x86_inst_encoder: directed test-plan steps plus random
// descriptors checked against a queue-based byte-stream model.
module tb_x86_inst_encoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  x86_inst_encoder_if #(.DISP_W(32)) ifc ();
`ifdef ENC_ASCII_TRACE_EN
  logic [191:0] trace_stream;
`endif

  x86_inst_encoder #(.DISP_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
`ifdef ENC_ASCII_TRACE_EN
    ,
    .trace_stream (trace_stream)
`endif
  );

  typedef struct {
    logic        leg_en;
    logic [7:0]  leg;
    logic        rex_en;
    logic [3:0]  wrxb;
    logic        two;
    logic [7:0]  opc;
    logic        mrm_en;
    logic [7:0]  mrm;
    logic [7:0]  sib;
    logic [31:0] disp;
  } desc_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Byte stream straight from the encoding rules
  task automatic build(input desc_t d);
    int mode, rm, nd;
    bit sp;
    exp_q.delete();
    if (d.leg_en) exp_q.push_back(d.leg);
    if (d.rex_en) exp_q.push_back(8'h40 + 8'(d.wrxb));
    if (d.two)    exp_q.push_back(8'h0F);
    exp_q.push_back(d.opc);
    if (d.mrm_en) begin
      exp_q.push_back(d.mrm);
      mode = int'(d.mrm) / 64;
      rm   = int'(d.mrm) % 8;
      sp   = (mode != 3) && (rm == 4);
      if (sp) exp_q.push_back(d.sib);
      if (mode == 1)      nd = 1;
      else if (mode == 2) nd = 4;
      else if (mode == 0 && (rm == 5 || (sp && int'(d.sib) % 8 == 5))) nd = 4;
      else                nd = 0;
      for (int i = 0; i < nd; i++) exp_q.push_back(8'((d.disp >> (8*i)) & 32'hFF));
    end
  endtask

  function automatic logic [191:0] trace_model();
    string s;
    logic [191:0] t;
    s = "";
    for (int i = 0; i < exp_q.size() && i < 8; i++) s = {s, $sformatf("%02x ", exp_q[i])};
    t = {24{8'h20}};
    for (int k = 0; k < s.len(); k++) t[191 - 8*k -: 8] = s[k];
    return t;
  endfunction

  function automatic desc_t mk(input logic le, input logic [7:0] l, input logic re,
                               input logic [3:0] w, input logic tw, input logic [7:0] o,
                               input logic me, input logic [7:0] m, input logic [7:0] sb,
                               input logic [31:0] dp);
    desc_t d;
    d.leg_en = le; d.leg = l; d.rex_en = re; d.wrxb = w; d.two = tw;
    d.opc = o; d.mrm_en = me; d.mrm = m; d.sib = sb; d.disp = dp;
    return d;
  endfunction

  task automatic scramble();
    ifc.in_legacy_en = 1'($urandom); ifc.in_legacy = 8'($urandom);
    ifc.in_rex_en = 1'($urandom);    ifc.in_rex_wrxb = 4'($urandom);
    ifc.in_two_byte = 1'($urandom);  ifc.in_opcode = 8'($urandom);
    ifc.in_modrm_en = 1'($urandom);  ifc.in_modrm = 8'($urandom);
    ifc.in_sib = 8'($urandom);       ifc.in_disp = $urandom;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic do_accept(input desc_t d);
    int n;
    build(d);
    n = 0;
    while (!ifc.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", 192'(ifc.in_ready), 192'(1));
    ifc.in_legacy_en = d.leg_en; ifc.in_legacy = d.leg;
    ifc.in_rex_en = d.rex_en;    ifc.in_rex_wrxb = d.wrxb;
    ifc.in_two_byte = d.two;     ifc.in_opcode = d.opc;
    ifc.in_modrm_en = d.mrm_en;  ifc.in_modrm = d.mrm;
    ifc.in_sib = d.sib;          ifc.in_disp = d.disp;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    scramble();
    #1;
    chk("inst_len", 192'(ifc.inst_len), 192'(exp_q.size()));
    chk("first_valid", 192'(ifc.out_valid), 192'(1));
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles at stall_idx
  task automatic collect(input int mode, input int stall_idx);
    int idx, cyc, stalls;
    bit r;
    idx = 0; cyc = 0; stalls = 0;
    while (idx < exp_q.size() && cyc < 200) begin
      ifc.in_valid = 1'b0;
      r = 1'b1;
      if (mode == 1) r = ($urandom_range(0, 3) != 0);
      if (mode == 2 && idx == stall_idx && stalls < 3) begin
        r = 1'b0;
        stalls++;
        scramble();
        ifc.in_valid = 1'b1;
      end
      ifc.out_ready = r;
      #1;
      chk("busy_valid", 192'(ifc.out_valid), 192'(1));
      if (mode == 2 && !r) begin
        chk("busy_in_ready", 192'(ifc.in_ready), 192'(0));
        chk("hold_byte", 192'(ifc.out_byte), 192'(exp_q[idx]));
      end
      if (ifc.out_valid && r) begin
        chk($sformatf("byte%0d", idx), 192'(ifc.out_byte), 192'(exp_q[idx]));
        chk($sformatf("last%0d", idx), 192'(ifc.out_last), 192'(idx == exp_q.size() - 1));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    ifc.in_valid = 1'b0;
    if (idx < exp_q.size()) chk("stream_timeout", 192'(idx), 192'(exp_q.size()));
    #1;
    chk("end_valid", 192'(ifc.out_valid), 192'(0));
    chk("end_in_ready", 192'(ifc.in_ready), 192'(1));
    chk("end_byte", 192'(ifc.out_byte), 192'(0));
    chk("end_len", 192'(ifc.inst_len), 192'(exp_q.size()));
`ifdef ENC_ASCII_TRACE_EN
    chk("trace", trace_stream, trace_model());
`endif
  endtask

  initial begin
    desc_t d;
    reset = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 192'(ifc.out_valid), 192'(0));
    chk("rst_in_ready", 192'(ifc.in_ready), 192'(0));
    chk("rst_out_byte", 192'(ifc.out_byte), 192'(0));
    chk("rst_out_last", 192'(ifc.out_last), 192'(0));
    chk("rst_inst_len", 192'(ifc.inst_len), 192'(0));
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_ready", 192'(ifc.in_ready), 192'(1));

    // Single byte
    do_accept(mk(0, 8'h00, 0, 4'h0, 0, 8'h55, 0, 8'h00, 8'h00, 32'h0));
    collect(0, 0);
    // REX + ModRM, register forms
    do_accept(mk(0, 8'h00, 1, 4'b1000, 0, 8'h89, 1, 8'hE5, 8'h00, 32'h0));
    collect(0, 0);
    do_accept(mk(0, 8'h00, 1, 4'b1000, 0, 8'h89, 1, 8'hE4, 8'h77, 32'h0));
    collect(0, 0);
    // Legacy + 0F + SIB + disp8
    do_accept(mk(1, 8'h66, 0, 4'h0, 1, 8'h1F, 1, 8'h44, 8'h00, 32'h0));
    collect(0, 0);
    // RIP-relative disp32, then SIB with no base and disp32
    do_accept(mk(0, 8'h00, 0, 4'h0, 0, 8'h8B, 1, 8'h05, 8'h00, 32'h12345678));
    collect(0, 0);
    do_accept(mk(0, 8'h00, 0, 4'h0, 0, 8'h8B, 1, 8'h04, 8'h25, 32'hCAFEBABE));
    collect(0, 0);
    // Opcode 0x0F without escape, maximum length with disp32
    do_accept(mk(0, 8'h00, 0, 4'h0, 0, 8'h0F, 0, 8'h00, 8'h00, 32'h0));
    collect(0, 0);
    do_accept(mk(1, 8'hF0, 1, 4'hF, 1, 8'hB1, 1, 8'h8C, 8'hD3, 32'h89ABCDEF));
    collect(1, 0);
    // Backpressure on ModRM with a competing descriptor
    do_accept(mk(0, 8'h00, 1, 4'b1000, 0, 8'h89, 1, 8'hE5, 8'h00, 32'h0));
    collect(2, 2);

    // Reset while the second byte of a 6-byte instruction is presented
    do_accept(mk(1, 8'h66, 0, 4'h0, 1, 8'h1F, 1, 8'h44, 8'h00, 32'h0));
    ifc.out_ready = 1'b1;
    #1;
    chk("abort_byte0", 192'(ifc.out_byte), 192'(8'h66));
    @(negedge clk);
    #1;
    chk("abort_byte1", 192'(ifc.out_byte), 192'(8'h0F));
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_valid", 192'(ifc.out_valid), 192'(0));
    chk("abort_last", 192'(ifc.out_last), 192'(0));
    chk("abort_len", 192'(ifc.inst_len), 192'(0));
    chk("abort_ready_in_rst", 192'(ifc.in_ready), 192'(0));
`ifdef ENC_ASCII_TRACE_EN
    chk("abort_trace", trace_stream, {24{8'h20}});
`endif
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_ready", 192'(ifc.in_ready), 192'(1));
    do_accept(mk(0, 8'h00, 1, 4'b0101, 0, 8'h8B, 1, 8'h45, 8'h00, 32'h000000F8));
    collect(0, 0);

    // Random descriptors with random backpressure
    for (int n = 0; n < 40; n++) begin
      d = mk(1'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
             8'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), $urandom);
      if ($urandom_range(0, 2) == 0) d.mrm[2:0] = 3'($urandom_range(4, 5));
      if ($urandom_range(0, 2) == 0) d.sib[2:0] = 3'b101;
      do_accept(d);
      collect(1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/x86_inst_encoder.md
Name: x86_inst_encoder

Overview:
- Serializes one structured x86-64 instruction descriptor into its byte stream, one byte per handshake.
- Field order: legacy prefix, REX, 0F escape, opcode, ModRM, SIB, displacement.
- It is the producer side of the instruction-byte format the fetch/decode path consumes. It generates directed instruction streams for decoder testing and feeds them into the fetch buffer.

Parameters:
- DISP_W, 32, width of the displacement input; at most 4 bytes are ever emitted.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  descriptor valid
- in_ready  output  1  encoder can accept a descriptor
- in_legacy_en  input  1  emit legacy prefix byte
- in_legacy  input  8  legacy prefix value, emitted as-is
- in_rex_en  input  1  emit REX byte
- in_rex_wrxb  input  4  REX.W/R/X/B bits
- in_two_byte  input  1  emit 0x0F escape before opcode
- in_opcode  input  8  opcode byte
- in_modrm_en  input  1  emit ModRM (and dependent SIB/disp)
- in_modrm  input  8  ModRM byte
- in_sib  input  8  SIB byte
- in_disp  input  DISP_W  displacement, little-endian source
- out_valid  output  1  out_byte valid
- out_ready  input  1  sink accepts byte
- out_byte  output  8  current byte
- out_last  output  1  current byte is final byte of the instruction
- inst_len  output  4  total byte count of last accepted instruction

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`.
- **States:** IDLE, LEGACY, REX, ESC, OPC, MODRM, SIB, DISP.
- **Reset values:** state=IDLE, out_valid=0, out_byte=0, out_last=0, inst_len=0, disp counter=0. in_ready is 0 while reset is asserted.
- **Accept:** in_ready = (state==IDLE). On in_valid&&in_ready, latch all in_* fields and go to the first enabled state. Order is LEGACY→REX→ESC→OPC; OPC is always present.
- **inst_len at accept:** registered on the accept cycle as 1 + legacy_en + rex_en + two_byte + modrm_en + sib_present + disp_bytes. It holds until the next accept.
- **Latency:** first byte valid the cycle after accept.
- **Byte values:**
  - REX byte = {4'b0100, wrxb}.
  - ESC byte = 0x0F.
- **Dependent fields (when modrm_en):**
  - mod=modrm[7:6], rm=modrm[2:0].
  - sib_present = (mod!=11 && rm==100).
  - disp_bytes = 1 if mod==01.
  - disp_bytes = 4 if mod==10.
  - disp_bytes = 4 if mod==00 && (rm==101 || (sib_present && sib[2:0]==101)).
  - disp_bytes = 0 otherwise.
  - With modrm_en=0: no SIB, no disp.
- **DISP state:** emits in_disp bytes LSB first; a 2-bit counter selects the byte.
- **Handshake:**
  - out_valid = (state!=IDLE).
  - out_byte and out_last stay stable while out_valid && !out_ready.
  - Advance only on out_valid&&out_ready.
  - out_byte is 0 in IDLE.
- **out_last:** asserted exactly on the final byte. After its handshake, return to IDLE; in_ready rises the next cycle. This gives a one-cycle bubble between instructions, by design.
- **No overlap:** in_valid while busy is ignored; fields latched at accept are immune to input changes.
- **Reset mid-instruction:** aborts immediately. No out_last is produced for the aborted instruction; inst_len clears to 0.
- **No content checking:** opcode 0x0F with two_byte=0 is emitted as a single byte. Legacy values are not validated. Maximum length is 10, so no overflow handling is needed.

Optional Feature:
- Macro: ENC_ASCII_TRACE_EN.
- **When defined**, adds output port trace_stream [191:0], an ASCII hex trace.
  - Each handshaken byte appends two lowercase hex chars plus a space, MSB-first from bit 191.
  - Unused positions are spaces (0x20).
  - The trace clears to all spaces on accept and on reset.
  - Only the first 8 bytes fit; later bytes are dropped from the trace but still emitted on out_byte.
  - Final value is stable from the cycle after out_last handshake until the next accept.
- **When undefined:** the port and its logic are absent; all other behaviour is identical.

Test Plan:
- **Single byte:** opcode 0x55, all enables 0, out_ready=1 → one byte 0x55 with out_last=1; inst_len=1; in_ready back high 2 cycles after accept.
- **REX + ModRM:** rex_en wrxb=1000, opcode 0x89, modrm 0xE5 → 0x48, 0x89, 0xE5, last on 0xE5, inst_len=3. Repeat with modrm 0xE4 (mod=11, rm=100) → no SIB, 3 bytes.
- **Full prefix/SIB/disp8:** legacy 0x66, two_byte, opcode 0x1F, modrm 0x44, sib 0x00, disp 0x00 → 66 0F 1F 44 00 00, inst_len=6. With ENC_ASCII_TRACE_EN: trace "66 0f 1f 44 00 00 " space-padded.
- **RIP-relative disp32:** opcode 0x8B, modrm 0x05, disp 0x12345678 → 8B 05 78 56 34 12, inst_len=6. Also modrm 0x04 with sib 0x25 → 8B 04 25 + 4 disp bytes, inst_len=7.
- **Backpressure and busy:** out_ready low 3 cycles while ModRM is presented → out_byte held at ModRM, no duplicate or skipped bytes. A new in_valid during this time → in_ready=0 and the descriptor is not latched.
- **Reset mid-stream:** reset on the 2nd byte of a 6-byte instruction → next cycle out_valid=0, inst_len=0, in_ready=1 after reset release; the following instruction encodes correctly.
